// File: rtl/counter_output_checker.sv
// Golden up-counter checker for the counter wrapper outputs; result is registered, DONE is reached LATENCY+1+CHECK_CYCLES cycles after start.
// No backpressure; optional first-mismatch capture is built when FIRST_FAIL_CAPTURE_EN is defined.
`timescale 1ns/1ps

module counter_output_checker #(
  parameter int WIDTH        = 16,
  parameter int LATENCY      = 1,
  parameter int CHECK_CYCLES = 1024,
  parameter int MISMATCH_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stim_reset,
  input  logic                  stim_enable,
  input  logic [WIDTH-1:0]      dut_count,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [MISMATCH_W-1:0] mismatch_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [15:0]           fail_cycle,
  output logic [WIDTH-1:0]      fail_expected,
  output logic [WIDTH-1:0]      fail_actual
`endif
);

  localparam int IDX_W = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, CHECK, DONE} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      exp_cnt;
  logic [WIDTH-1:0]      exp_d;
  logic [2:0]            flush_cnt;
  logic [IDX_W-1:0]      idx;
  logic [MISMATCH_W-1:0] cnt_nxt;
  logic                  start_run;
  logic                  mismatch;

  // Golden counter runs in every state so it tracks the fabric across runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         exp_cnt <= '0;
    else if (stim_reset)  exp_cnt <= '0;
    else if (stim_enable) exp_cnt <= exp_cnt + 1'b1;
  end

  generate
    if (LATENCY == 0) begin : g_no_dly
      assign exp_d = exp_cnt;
    end else begin : g_dly
      logic [WIDTH-1:0] dly [LATENCY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= exp_cnt;
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign exp_d = dly[LATENCY-1];
    end
  endgenerate

  assign start_run = ((state == IDLE) || (state == DONE)) && start;
  assign mismatch  = (state == CHECK) && (dut_count != exp_d);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = mismatch_cnt;
    case (state)
      IDLE, DONE: if (start) state_nxt = FLUSH;
      FLUSH:      if (flush_cnt == 3'(LATENCY)) state_nxt = CHECK;
      CHECK:      if (idx == IDX_W'(CHECK_CYCLES - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (start_run)
      cnt_nxt = '0;
    else if (mismatch && !(&mismatch_cnt))
      cnt_nxt = mismatch_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      idx          <= '0;
      mismatch_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state        <= state_nxt;
      mismatch_cnt <= cnt_nxt;
      busy         <= (state_nxt == FLUSH) || (state_nxt == CHECK);
      done         <= (state_nxt == DONE);
      pass         <= (state_nxt == DONE) && (cnt_nxt == '0);
      if (start_run) begin
        flush_cnt <= '0;
        idx       <= '0;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else if (state == CHECK) begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // A zero count before this cycle's increment marks the first mismatch of the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_cycle    <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (start_run) begin
      fail_cycle    <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (mismatch && (mismatch_cnt == '0)) begin
      fail_cycle    <= 16'(idx);
      fail_expected <= exp_d;
      fail_actual   <= dut_count;
    end
  end
`endif

endmodule

// File: tb/tb_counter_output_checker.sv
// Directed bench for counter_output_checker with a behavioural fabric counter and scoreboard of run results.
`timescale 1ns/1ps

module tb_counter_output_checker;
  localparam int W = 16;
  localparam int L = 1;
  localparam int C = 20;

  typedef struct {
    int          mis;
    logic        pass;
    int          fc;
    logic [15:0] fe;
    logic [15:0] fa;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, stim_reset, stim_enable, win_clr;
  logic [W-1:0] dut_count, sat_count;
  logic         busy, done, pass, sat_busy, sat_done, sat_pass;
  logic [15:0]  mis_cnt;
  logic [1:0]   sat_mis;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [15:0]  fail_cycle, sat_fc;
  logic [W-1:0] fail_expected, fail_actual, sat_fe, sat_fa;
`endif

  logic [W-1:0] fab_cnt, fab_pad, fab_pad_q;
  int           win_cyc = 0;
  int           fault_mode = 0;
  int           checks = 0;
  int           failures = 0;
  exp_t         sb[$];

  // Fabric model: count register observed through one pad register.
  always @(posedge clk) begin
    if (stim_reset)       fab_cnt <= '0;
    else if (stim_enable) fab_cnt <= fab_cnt + 1'b1;
    fab_pad   <= fab_cnt;
    fab_pad_q <= fab_pad;
    win_cyc   <= win_clr ? 0 : win_cyc + 1;
  end

  // Check cycle k is seen while win_cyc == k+2.
  always_comb begin
    dut_count = fab_pad;
    if (fault_mode == 1 && win_cyc >= 4 && win_cyc <= 8) dut_count = fab_pad | 16'h0008;
    if (fault_mode == 2 && win_cyc == 11) dut_count = fab_pad_q;
  end
  assign sat_count = ~fab_pad;

  counter_output_checker #(.WIDTH(W), .LATENCY(L), .CHECK_CYCLES(C), .MISMATCH_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stim_reset(stim_reset),
    .stim_enable(stim_enable), .dut_count(dut_count), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mis_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_cycle(fail_cycle), .fail_expected(fail_expected), .fail_actual(fail_actual)
`endif
  );

  counter_output_checker #(.WIDTH(W), .LATENCY(L), .CHECK_CYCLES(C), .MISMATCH_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .stim_reset(stim_reset),
    .stim_enable(stim_enable), .dut_count(sat_count), .busy(sat_busy), .done(sat_done),
    .pass(sat_pass), .mismatch_cnt(sat_mis)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_cycle(sat_fc), .fail_expected(sat_fe), .fail_actual(sat_fa)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int mis, input logic p, input int fc, input logic [15:0] fe,
                      input logic [15:0] fa);
    exp_t e;
    e.mis = mis; e.pass = p; e.fc = fc; e.fe = fe; e.fa = fa;
    sb.push_back(e);
  endtask

  // Start a run; optionally clear golden and fabric in the same cycle.
  task automatic launch(input int fm, input logic clr);
    @(negedge clk);
    fault_mode = fm; start = 1'b1; win_clr = 1'b1; stim_reset = clr;
    @(negedge clk);
    start = 1'b0; win_clr = 1'b0; stim_reset = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_run(input string tag, input int rst_at, input int ign_at);
    exp_t e;
    int   n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      stim_reset = (win_cyc == rst_at);
      start      = (win_cyc == ign_at);
    end
    stim_reset = 1'b0; start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(L + 1 + C));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_mismatch_cnt"}, 32'(mis_cnt), 32'(e.mis));
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
      check({tag, "_fail_cycle"}, 32'(fail_cycle), 32'(e.fc));
      check({tag, "_fail_expected"}, 32'(fail_expected), 32'(e.fe));
      check({tag, "_fail_actual"}, 32'(fail_actual), 32'(e.fa));
`endif
    end
    fault_mode = 0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; stim_reset = 1'b1; stim_enable = 1'b1; win_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mismatch_cnt", 32'(mis_cnt), 32'd0);
    reset_n = 1'b1; stim_reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean run with an ignored start mid-CHECK; saturating checker sees all-wrong data.
    push(0, 1'b1, 0, 16'h0, 16'h0);
    launch(0, 1'b1);
    finish_run("t1_clean", -1, 10);
    check("t6_sat_mismatch_cnt", 32'(sat_mis), 32'd3);
    check("t6_sat_pass", 32'(sat_pass), 32'd0);
    @(negedge clk);
    check("t1_done_held", 32'(done), 32'd1);

    // Bit 3 forced high in check cycles 2..6 (golden 3..7).
    push(5, 1'b0, 2, 16'h0003, 16'h000B);
    launch(1, 1'b1);
    finish_run("t2_bit3", -1, -1);

    // stim_reset during check cycle 7, DUT on time.
    push(0, 1'b1, 0, 16'h0, 16'h0);
    launch(0, 1'b1);
    finish_run("t4_clr_ok", 9, -1);

    // Same, but DUT shows zero one cycle late (check cycle 9 shows 9).
    push(1, 1'b0, 9, 16'h0000, 16'h0009);
    launch(2, 1'b1);
    finish_run("t4_clr_late", 9, -1);

    // reset_n at check cycle 10 aborts the run.
    launch(0, 1'b1);
    n = 0;
    while (win_cyc != 12 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_cycle10", 32'(win_cyc), 32'd12);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_pass", 32'(pass), 32'd0);
    check("t5_abort_mismatch_cnt", 32'(mis_cnt), 32'd0);
    reset_n = 1'b1;
    push(0, 1'b1, 0, 16'h0, 16'h0);
    launch(0, 1'b1);
    finish_run("t5_rerun", -1, -1);

    // Let the counters run up to the wrap, then check across 0xFFFF -> 0x0000.
    n = 0;
    while (fab_cnt != 16'hFFF0 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("t3_preload", 32'(fab_cnt), 32'h0000FFF0);
    push(0, 1'b1, 0, 16'h0, 16'h0);
    launch(0, 1'b0);
    finish_run("t3_wrap", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
